// File: rtl/display_frame_scheduler.sv
`timescale 1ns/1ps
// Triple-buffer frame scheduler: picks newest frame at vsync, issues DMA read.
// Optional DISP_SCHED_STATS_EN adds repeat/drop frame counters.
module display_frame_scheduler #(
  parameter int unsigned            ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]      BUF_BASE    = 'h0100_0000,
  parameter logic [ADDR_W-1:0]      BUF_STRIDE  = 'h0040_0000,
  parameter logic [23:0]            FRAME_BYTES = 24'd614400
) (
  input  logic              lvds_slowclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              vsync_fall,
  input  logic              wr_frame_done,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx,
  output logic              dma_cmd_valid,
  input  logic              dma_cmd_ready,
  output logic [ADDR_W-1:0] dma_cmd_addr,
  output logic [23:0]       dma_cmd_len,
  input  logic              dma_done,
  output logic              late_err,
  output logic [31:0]       frame_repeat_cnt,
  output logic [31:0]       frame_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ISSUE   = 2'd2,
    BUSY    = 2'd3
  } state_t;

  state_t state, state_n;

  logic [1:0] wr_q, rd_q, lat_q;
  logic       rv_q, hf_q;
  logic [1:0] wr_n, rd_n, lat_n;
  logic       rv_n, hf_n;
  logic       sel, sel_new, sel_rep;

  // Done rotation first, then selection on the rotated view.
  always_comb begin
    wr_n    = wr_q;
    rd_n    = rd_q;
    lat_n   = lat_q;
    rv_n    = rv_q;
    hf_n    = hf_q;
    sel     = 1'b0;
    sel_new = 1'b0;
    sel_rep = 1'b0;
    if (wr_frame_done) begin
      lat_n = wr_q;
      wr_n  = lat_q;
      rv_n  = 1'b1;
      hf_n  = 1'b1;
    end
    sel     = (state == WAIT_VS) && enable && vsync_fall && hf_n;
    sel_new = sel && rv_n;
    sel_rep = sel && !rv_n;
    if (sel_new) begin
      rv_n = 1'b0;
      if (wr_frame_done) begin
        rd_n  = wr_q;
        wr_n  = rd_q;
        lat_n = lat_q;
      end else begin
        rd_n  = lat_q;
        lat_n = rd_q;
      end
    end
  end

  always_ff @(posedge lvds_slowclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enable) state_n = WAIT_VS;
      WAIT_VS: begin
        if (!enable)  state_n = IDLE;
        else if (sel) state_n = ISSUE;
      end
      ISSUE:   if (dma_cmd_ready) state_n = BUSY;
      BUSY:    if (dma_done) state_n = enable ? WAIT_VS : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dma_cmd_valid = (state == ISSUE);
    dma_cmd_len   = FRAME_BYTES;
  end

  always_ff @(posedge lvds_slowclk) begin
    if (rst) begin
      wr_q         <= 2'd0;
      rd_q         <= 2'd2;
      lat_q        <= 2'd1;
      rv_q         <= 1'b0;
      hf_q         <= 1'b0;
      late_err     <= 1'b0;
      dma_cmd_addr <= BUF_BASE + ADDR_W'(2) * BUF_STRIDE;
    end else begin
      wr_q  <= wr_n;
      rd_q  <= rd_n;
      lat_q <= lat_n;
      rv_q  <= rv_n;
      hf_q  <= hf_n;
      if (vsync_fall && (state == ISSUE || state == BUSY))
        late_err <= 1'b1;
      if (sel)
        dma_cmd_addr <= BUF_BASE + ADDR_W'(rd_n) * BUF_STRIDE;
    end
  end

  assign wr_buf_idx = wr_q;
  assign rd_buf_idx = rd_q;

`ifdef DISP_SCHED_STATS_EN
  logic [31:0] rep_q, drop_q;

  always_ff @(posedge lvds_slowclk) begin
    if (rst) begin
      rep_q  <= 32'd0;
      drop_q <= 32'd0;
    end else begin
      if (sel_rep)
        rep_q <= rep_q + 32'd1;
      if (wr_frame_done && rv_q)
        drop_q <= drop_q + 32'd1;
    end
  end

  assign frame_repeat_cnt = rep_q;
  assign frame_drop_cnt   = drop_q;
`else
  logic unused_rep;
  assign unused_rep       = sel_rep;
  assign frame_repeat_cnt = 32'd0;
  assign frame_drop_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_display_frame_scheduler.sv
`timescale 1ns/1ps
// Directed bench for display_frame_scheduler.
module tb_display_frame_scheduler;

  localparam logic [31:0] A0 = 32'h0100_0000;
  localparam logic [31:0] A1 = 32'h0140_0000;
  localparam logic [31:0] A2 = 32'h0180_0000;

`ifdef DISP_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, vsync_fall, wr_frame_done;
  logic        dma_cmd_ready, dma_done;
  logic [1:0]  wr_buf_idx, rd_buf_idx;
  logic        dma_cmd_valid, late_err;
  logic [31:0] dma_cmd_addr, frame_repeat_cnt, frame_drop_cnt;
  logic [23:0] dma_cmd_len;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  display_frame_scheduler dut (
    .lvds_slowclk     (clk),
    .rst              (rst),
    .enable           (enable),
    .vsync_fall       (vsync_fall),
    .wr_frame_done    (wr_frame_done),
    .wr_buf_idx       (wr_buf_idx),
    .rd_buf_idx       (rd_buf_idx),
    .dma_cmd_valid    (dma_cmd_valid),
    .dma_cmd_ready    (dma_cmd_ready),
    .dma_cmd_addr     (dma_cmd_addr),
    .dma_cmd_len      (dma_cmd_len),
    .dma_done         (dma_done),
    .late_err         (late_err),
    .frame_repeat_cnt (frame_repeat_cnt),
    .frame_drop_cnt   (frame_drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
    vsync_fall    = 1'b0;
    wr_frame_done = 1'b0;
    dma_done      = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; vsync_fall = 1'b0; wr_frame_done = 1'b0;
    dma_cmd_ready = 1'b0; dma_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_wr", wr_buf_idx, 2'd0);
    chk("rst_rd", rd_buf_idx, 2'd2);
    chk("rst_valid", dma_cmd_valid, 1'b0);
    chk("rst_addr", dma_cmd_addr, A2);
    chk("rst_late", late_err, 1'b0);
    chk("rst_rep", frame_repeat_cnt, 32'd0);
    chk("rst_drop", frame_drop_cnt, 32'd0);

    // 1: vsync before any frame
    enable = 1'b1;
    step();
    vsync_fall = 1'b1;
    step();
    chk("t1_valid_a", dma_cmd_valid, 1'b0);
    step();
    chk("t1_valid_b", dma_cmd_valid, 1'b0);
    chk("t1_rd", rd_buf_idx, 2'd2);
    chk("t1_rep", frame_repeat_cnt, 32'd0);

    // 2: first frame
    wr_frame_done = 1'b1;
    step();
    chk("t2_wr_rot", wr_buf_idx, 2'd1);
    vsync_fall = 1'b1;
    step();
    chk("t2_valid", dma_cmd_valid, 1'b1);
    chk("t2_addr", dma_cmd_addr, A0);
    chk("t2_len", dma_cmd_len, 24'd614400);
    chk("t2_rd", rd_buf_idx, 2'd0);
    chk("t2_wr", wr_buf_idx, 2'd1);

    // 3: backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", dma_cmd_valid, 1'b1);
      chk("t3_hold_addr", dma_cmd_addr, A0);
    end
    dma_cmd_ready = 1'b1;
    step();
    dma_cmd_ready = 1'b0;
    chk("t3_valid_drop", dma_cmd_valid, 1'b0);
    dma_done = 1'b1;
    step();

    // 4: drop then repeat
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b1;
    step();
    chk("t4_drop", frame_drop_cnt, cnt(1));
    chk("t4_wr", wr_buf_idx, 2'd1);
    vsync_fall = 1'b1;
    step();
    chk("t4_valid", dma_cmd_valid, 1'b1);
    chk("t4_addr", dma_cmd_addr, A2);
    chk("t4_rd", rd_buf_idx, 2'd2);
    dma_cmd_ready = 1'b1;
    step();
    dma_cmd_ready = 1'b0;
    dma_done = 1'b1;
    step();
    vsync_fall = 1'b1;
    step();
    chk("t4_rep", frame_repeat_cnt, cnt(1));
    chk("t4_rep_valid", dma_cmd_valid, 1'b1);
    chk("t4_rep_addr", dma_cmd_addr, A2);
    chk("t4_rep_rd", rd_buf_idx, 2'd2);
    dma_cmd_ready = 1'b1;
    step();
    dma_cmd_ready = 1'b0;

    // 5: late vsync in BUSY, then simultaneous done+vsync
    vsync_fall = 1'b1;
    step();
    chk("t5_late", late_err, 1'b1);
    chk("t5_no_cmd", dma_cmd_valid, 1'b0);
    chk("t5_rd", rd_buf_idx, 2'd2);
    step();
    chk("t5_no_cmd_b", dma_cmd_valid, 1'b0);
    chk("t5_rep_same", frame_repeat_cnt, cnt(1));
    dma_done = 1'b1;
    step();
    wr_frame_done = 1'b1;
    vsync_fall = 1'b1;
    step();
    chk("t5_sim_rd", rd_buf_idx, 2'd1);
    chk("t5_sim_wr", wr_buf_idx, 2'd2);
    chk("t5_sim_valid", dma_cmd_valid, 1'b1);
    chk("t5_sim_addr", dma_cmd_addr, A1);
    chk("t5_sim_drop", frame_drop_cnt, cnt(1));
    chk("t5_late_sticky", late_err, 1'b1);
    dma_cmd_ready = 1'b1;
    step();
    dma_cmd_ready = 1'b0;
    dma_done = 1'b1;
    step();

    // 6: enable drop in BUSY, then reset mid-ISSUE
    vsync_fall = 1'b1;
    step();
    chk("t6_rep", frame_repeat_cnt, cnt(2));
    chk("t6_addr", dma_cmd_addr, A1);
    dma_cmd_ready = 1'b1;
    step();
    dma_cmd_ready = 1'b0;
    enable = 1'b0;
    step();
    dma_done = 1'b1;
    step();
    wr_frame_done = 1'b1;
    step();
    chk("t6_idle_rot_wr", wr_buf_idx, 2'd0);
    vsync_fall = 1'b1;
    step();
    chk("t6_idle_valid", dma_cmd_valid, 1'b0);
    step();
    chk("t6_idle_valid_b", dma_cmd_valid, 1'b0);
    chk("t6_idle_rd", rd_buf_idx, 2'd1);
    enable = 1'b1;
    step();
    vsync_fall = 1'b1;
    step();
    chk("t6_issue_valid", dma_cmd_valid, 1'b1);
    chk("t6_issue_rd", rd_buf_idx, 2'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", dma_cmd_valid, 1'b0);
    chk("t6_rst_wr", wr_buf_idx, 2'd0);
    chk("t6_rst_rd", rd_buf_idx, 2'd2);
    chk("t6_rst_late", late_err, 1'b0);
    chk("t6_rst_rep", frame_repeat_cnt, 32'd0);
    chk("t6_rst_drop", frame_drop_cnt, 32'd0);
    dma_done = 1'b1;
    step();
    chk("t6_done_ign", dma_cmd_valid, 1'b0);
    vsync_fall = 1'b1;
    step();
    step();
    chk("t6_no_frame", dma_cmd_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
